// File: rtl/mul_shift_add.sv
// Iterative shift-and-add multiplier (low N bits of a*b, RV32 MUL semantics).
// One partial product a<<k per cycle comes from an internal logical left
// shifter whose shift amount is the bit counter. Exactly N accumulate cycles
// per operation, then the result is held under a valid/ready handshake.

// Combinational logical left shifter built as a log2(N)-stage barrel.
module shift_left_logical #(
   parameter int N = 32
) (
   input  logic [N-1:0]         a,
   input  logic [$clog2(N)-1:0] shamt,
   output logic [N-1:0]         y
);
   localparam int S = $clog2(N);

   logic [S:0][N-1:0] stage;

   assign stage[0] = a;

   genvar gi;
   generate
      for (gi = 0; gi < S; gi++) begin : g_stage
         // Stage gi shifts by 2**gi when the matching shamt bit is set.
         assign stage[gi+1] = shamt[gi] ? (stage[gi] << (1 << gi)) : stage[gi];
      end
   endgenerate

   assign y = stage[S];
endmodule

module mul_shift_add #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] product
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_reg;
   logic [N-1:0]  acc_reg;
   logic [CW-1:0] count_reg;
   logic [N-1:0]  a_reg;
   logic [N-1:0]  b_reg;
   logic          o_valid_reg;
   logic [N-1:0]  shifter_out;
   logic [N-1:0]  partial;

   // Partial product a_reg << count comes from the shared shifter block.
   shift_left_logical #(
      .N(N)
   ) u_shl (
      .a     (a_reg),
      .shamt (count_reg),
      .y     (shifter_out)
   );

   // Multiplier bit selects whether this cycle's shifted multiplicand is added.
   always_comb begin
      partial = '0;
      if (b_reg[count_reg]) begin
         partial = shifter_out;
      end
   end

   // Control FSM and datapath registers; o_valid is registered with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         count_reg   <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         o_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  acc_reg   <= '0;
                  count_reg <= '0;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               // Sum wraps modulo 2**N; the carry out is deliberately lost.
               acc_reg <= acc_reg + partial;
               if (count_reg == LAST) begin
                  state_reg   <= DONE;
                  o_valid_reg <= 1'b1;
               end else begin
                  count_reg <= count_reg + CW'(1);
               end
            end
            DONE: begin
               if (o_ready) begin
                  state_reg   <= IDLE;
                  o_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg   <= IDLE;
               o_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // Ready depends only on state and reset, never on the handshake inputs.
   assign i_ready = (state_reg == IDLE) && !rst;
   assign o_valid = o_valid_reg;
   assign product = acc_reg;
endmodule

// File: tb/tb_mul_shift_add.sv
// Directed bench for mul_shift_add: reset state, latency, arithmetic corners,
// backpressure, operand isolation, mid-operation reset and a random sweep.
module tb_mul_shift_add;
   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;

   mul_shift_add #(
      .N(32)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .a       (a),
      .b       (b),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one operation from an IDLE negedge. Cycle T is the accept cycle;
   // o_valid must be low in cycles T+1..T+32 and high in cycle T+33.
   // The result is then held for 'stall' cycles with o_ready low.
   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [31:0] exp_p, input int stall, input bit verbose);
      int  cyc;
      bit  seen;
      bit  early;
      check("i_ready_idle", {31'd0, i_ready}, 32'd1);
      a       = op_a;
      b       = op_b;
      i_valid = 1'b1;
      o_ready = (stall == 0);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      a       = $urandom;
      b       = $urandom;
      cyc   = 0;
      seen  = 1'b0;
      early = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (o_valid) seen = 1'b1;
         else if (i_ready !== 1'b0) early = 1'b1;
      end
      check("latency", 32'(cyc), 32'd33);
      check("busy_not_ready", {31'd0, early}, 32'd0);
      check("product", product, exp_p);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, o_valid}, 32'd1);
         check("hold_product", product, exp_p);
         check("hold_not_ready", {31'd0, i_ready}, 32'd0);
      end
      o_ready = 1'b1;
      @(negedge clk);
      check("post_o_valid", {31'd0, o_valid}, 32'd0);
      check("post_i_ready", {31'd0, i_ready}, 32'd1);
      o_ready = 1'b0;
      if (verbose) $display("op a=%h b=%h product=%h latency=%0d stall=%0d", op_a, op_b, product, cyc, stall);
   endtask

   initial begin
      int          cyc;
      bit          seen;
      bit          rose;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rexp;

      rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_i_ready", {31'd0, i_ready}, 32'd0);
      check("rst_o_valid", {31'd0, o_valid}, 32'd0);
      check("rst_product", product, 32'd0);
      rst = 1'b0;
      #1;

      // Basic and arithmetic corners.
      run_op(32'd3, 32'd5, 32'd15, 0, 1'b1);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 1'b1);
      run_op(32'h00010000, 32'h00010000, 32'h00000000, 0, 1'b1);
      run_op(32'h00000000, 32'h12345678, 32'h00000000, 0, 1'b1);
      run_op(32'h80000000, 32'h00000001, 32'h80000000, 0, 1'b1);
      run_op(32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 0, 1'b1);
      // Backpressure: result held for 5 cycles.
      run_op(32'h00001234, 32'h00000010, 32'h00012340, 5, 1'b1);

      // Operand isolation: i_valid stays high and operands churn during BUSY.
      a = 32'd7; b = 32'd9; i_valid = 1'b1; o_ready = 1'b1;
      @(posedge clk);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (o_valid) seen = 1'b1;
         else begin
            a = $urandom;
            b = $urandom;
         end
      end
      check("iso_latency", 32'(cyc), 32'd33);
      check("iso_product", product, 32'd63);
      check("iso_done_not_ready", {31'd0, i_ready}, 32'd0);
      a = 32'd11; b = 32'd13;
      @(negedge clk);
      check("iso_idle_ready", {31'd0, i_ready}, 32'd1);
      check("iso_idle_valid", {31'd0, o_valid}, 32'd0);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      @(negedge clk);
      check("iso_second_accept", {31'd0, i_ready}, 32'd0);
      cyc = 1; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (o_valid) seen = 1'b1;
      end
      check("iso2_latency", 32'(cyc), 32'd33);
      check("iso2_product", product, 32'd143);
      @(negedge clk);
      check("iso2_idle", {31'd0, i_ready}, 32'd1);
      o_ready = 1'b0;
      $display("isolation first=63 second=%h", product);

      // Reset in BUSY cycle 10 drops the operation.
      a = 32'd100; b = 32'd200; i_valid = 1'b1; o_ready = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_i_ready", {31'd0, i_ready}, 32'd0);
      @(negedge clk);
      check("midrst_o_valid", {31'd0, o_valid}, 32'd0);
      check("midrst_product", product, 32'd0);
      rst = 1'b0;
      #1;
      check("midrst_ready_after", {31'd0, i_ready}, 32'd1);
      rose = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_valid) rose = 1'b1;
      end
      check("midrst_no_output", {31'd0, rose}, 32'd0);
      $display("mid-op reset: dropped 100*200, o_valid rose=%0d", rose);
      o_ready = 1'b0;
      run_op(32'd2, 32'd21, 32'd42, 0, 1'b1);

      // Random sweep with random result stalls.
      for (int n = 0; n < 1000; n++) begin
         ra   = $urandom;
         rb   = $urandom;
         rexp = ra * rb;
         run_op(ra, rb, rexp, int'($urandom_range(0, 3)), 1'b0);
      end
      $display("random: 1000 operations issued");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
